// File: rtl/energy_lut_pkg.sv
// ----------------------------------------------------------------------------
// energy_lut_pkg: shared state type, default widths and a saturating helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package energy_lut_pkg;

  localparam int c_addr_w = 10;
  localparam int c_data_w = 64;
  localparam int c_tag_w  = 32;
  localparam int c_rd_lat = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    LOAD    = 2'd2
  } lut_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/energy_lut_out_fifo.sv
// ----------------------------------------------------------------------------
// energy_lut_out_fifo: synchronous result FIFO with occupancy count output.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module energy_lut_out_fifo
  import energy_lut_pkg::*;
#(
  parameter int WIDTH = c_data_w + c_tag_w,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  // Storage is cleared too so the head word reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(push) - c_cnt_w'(pop);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign valid = (r_count != '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/energy_coeff_lut_ctrl.sv
// ----------------------------------------------------------------------------
// energy_coeff_lut_ctrl: BRAM port-A sequencer for photon coefficient lookups
// and quiesced table reloads. Option ENERGY_LUT_STATS_EN adds stat counters.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module energy_coeff_lut_ctrl
  import energy_lut_pkg::*;
#(
  parameter int ADDR_W    = c_addr_w,
  parameter int DATA_W    = c_data_w,
  parameter int TAG_W     = c_tag_w,
  parameter int RD_LAT    = c_rd_lat,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ph_valid,
  output logic              ph_ready,
  input  logic [ADDR_W-1:0] ph_addr,
  input  logic [TAG_W-1:0]  ph_tag,
  output logic              co_valid,
  input  logic              co_ready,
  output logic [DATA_W-1:0] co_data,
  output logic [TAG_W-1:0]  co_tag,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              bram_en_a,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  input  logic [DATA_W-1:0] bram_rd_data
`ifdef ENERGY_LUT_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_stall
`endif
);

  localparam int c_cnt_w  = $clog2(OUT_DEPTH+1);
  localparam int c_fifo_w = DATA_W + TAG_W;

  lut_state_t          r_state;
  lut_state_t          w_next_state;
  logic [c_cnt_w-1:0]  r_inflight;
  logic [c_cnt_w-1:0]  w_fifo_count;
  logic [c_cnt_w:0]    w_occ;
  logic                w_credit_ok;
  logic                w_ph_fire;
  logic                w_ld_fire;
  logic                w_push;
  logic                w_pop;
  logic [RD_LAT:0]     r_tag_vld;
  logic [TAG_W-1:0]    r_tag_pipe [RD_LAT+1];
  logic [c_fifo_w-1:0] w_fifo_dout;

  assign w_ph_fire = ph_valid & ph_ready;
  assign w_ld_fire = ld_valid & ld_ready;
  assign w_push    = r_tag_vld[RD_LAT];
  assign w_pop     = co_valid & co_ready;

  // A slot being popped this cycle is already free, which keeps 1/cycle streaming.
  assign w_occ       = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) - {{c_cnt_w{1'b0}}, w_pop};
  assign w_credit_ok = (w_occ < (c_cnt_w+1)'(OUT_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ph_ready     = 1'b0;
    ld_ready     = 1'b0;
    case (r_state)
      RUN: begin
        ph_ready = w_credit_ok & ~rst;
        if (ld_start) begin
          w_next_state = QUIESCE;
        end
      end
      QUIESCE: begin
        if (r_inflight == '0) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  assign ld_busy = (r_state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en_a    <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
    end else begin
      bram_en_a <= w_ph_fire | w_ld_fire;
      bram_we   <= w_ld_fire;
      if (w_ld_fire) begin
        bram_addr    <= ld_addr;
        bram_wr_data <= ld_data;
      end else if (w_ph_fire) begin
        bram_addr <= ph_addr;
      end
    end
  end

  // Free-running tag line: the BRAM cannot stall, so neither can the tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= '0;
      r_inflight <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        r_tag_pipe[i] <= '0;
      end
    end else begin
      r_tag_vld     <= {r_tag_vld[RD_LAT-1:0], w_ph_fire};
      r_tag_pipe[0] <= ph_tag;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
      r_inflight <= r_inflight + c_cnt_w'(w_ph_fire) - c_cnt_w'(w_push);
    end
  end

  energy_lut_out_fifo #(
    .WIDTH (c_fifo_w),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({bram_rd_data, r_tag_pipe[RD_LAT]}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .valid (co_valid),
    .count (w_fifo_count)
  );

  assign co_data = w_fifo_dout[c_fifo_w-1:TAG_W];
  assign co_tag  = w_fifo_dout[TAG_W-1:0];

`ifdef ENERGY_LUT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_stall   <= '0;
    end else if (ld_start) begin
      stat_lookups <= '0;
      stat_stall   <= '0;
    end else begin
      if (w_ph_fire) begin
        stat_lookups <= sat_inc32(stat_lookups);
      end
      if (ph_valid && !ph_ready) begin
        stat_stall <= sat_inc32(stat_stall);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_energy_coeff_lut_ctrl.sv
// ----------------------------------------------------------------------------
// tb_energy_coeff_lut_ctrl: BRAM model, scoreboard and directed/random checks.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_energy_coeff_lut_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int TW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ph_valid, ph_ready;
  logic [AW-1:0] ph_addr;
  logic [TW-1:0] ph_tag;
  logic          co_valid, co_ready;
  logic [DW-1:0] co_data;
  logic [TW-1:0] co_tag;
  logic          ld_start, ld_valid, ld_ready, ld_last, ld_busy;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          bram_en_a, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wr_data;
  logic [DW-1:0] bram_rd_data = '0;
`ifdef ENERGY_LUT_STATS_EN
  logic [31:0]   stat_lookups, stat_stall;
`endif

  always #5 clk = ~clk;

  energy_coeff_lut_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .RD_LAT(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_addr(ph_addr), .ph_tag(ph_tag),
    .co_valid(co_valid), .co_ready(co_ready), .co_data(co_data), .co_tag(co_tag),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
    .bram_en_a(bram_en_a), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data)
`ifdef ENERGY_LUT_STATS_EN
    , .stat_lookups(stat_lookups), .stat_stall(stat_stall)
`endif
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return {16'hC0EF, 16'(a), 32'(a) ^ 32'h5A5A_0F0F};
  endfunction

  // BRAM port A model: two registered read stages, write when en & we.
  logic [DW-1:0] bram_mem [1024];
  logic [DW-1:0] bram_s1 = '0;
  bit            init_done = 1'b0;
  int            we_count = 0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) bram_mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else begin
      if (bram_en_a && bram_we) begin
        bram_mem[bram_addr] <= bram_wr_data;
        we_count <= we_count + 1;
      end
      if (bram_en_a && !bram_we) bram_s1 <= bram_mem[bram_addr];
      bram_rd_data <= bram_s1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference table: initial contents plus every word the loader handed over.
  logic [DW-1:0] ref_wr [int];

  function automatic logic [DW-1:0] ref_lookup(input int a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return init_word(a);
  endfunction

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } out_rec_t;

  out_rec_t         out_log[$];
  int               acc_log[$];
  logic [DW+TW-1:0] exp_q[$];
  int               cyc = 0;
  int               n_acc = 0;
  int               n_pop = 0;
  int               stall_seen = 0;

  always @(negedge clk) begin
    logic [DW+TW-1:0] e;
    cyc++;
    if (!rst) begin
      if (ph_valid && ph_ready) begin
        exp_q.push_back({ref_lookup(int'(ph_addr)), ph_tag});
        acc_log.push_back(cyc);
        n_acc++;
      end
      if (co_valid && co_ready) begin
        out_log.push_back('{cyc, co_data, co_tag});
        n_pop++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", co_data, e[DW+TW-1:TW]);
          check("sb_tag", co_tag, e[TW-1:0]);
        end
      end
      if ((ph_valid && ph_ready) || (co_valid && co_ready))
        check("credit_outstanding_le_depth", (n_acc - n_pop) <= DEPTH, 1'b1);
      if (ld_valid && ld_ready) ref_wr[int'(ld_addr)] = ld_data;
      if (ph_valid && !ph_ready) stall_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ld_ready(input string name);
    int w = 0;
    while (!ld_ready && w < 20) begin
      tick();
      w++;
    end
    check(name, ld_ready, 1'b1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vec[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ph_valid = 0; ph_addr = '0; ph_tag = '0; co_ready = 0;
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 8; i++) begin
      vec[i].addr = AW'(i);
      vec[i].tag  = 32'hA000_0000 + 32'(i);
      vec[i].exp  = init_word(i);
    end
    repeat (2) tick();

    // Reset state
    check("rst_ph_ready", ph_ready, 1'b0);
    check("rst_co_valid", co_valid, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_ld_busy", ld_busy, 1'b0);
    check("rst_bram_en", bram_en_a, 1'b0);
    check("rst_bram_we", bram_we, 1'b0);
    check("rst_bram_addr", bram_addr, '0);
    check("rst_co_data", co_data, '0);
    rst = 1'b0;
    tick();

    // 1: eight lookups streaming, latency and throughput
    co_ready = 1;
    acc_log.delete(); out_log.delete();
    for (int i = 0; i < 8; i++) begin
      ph_valid = 1; ph_addr = vec[i].addr; ph_tag = vec[i].tag;
      check("t1_ph_ready", ph_ready, 1'b1);
      tick();
    end
    ph_valid = 0;
    repeat (8) tick();
    check("t1_accepted", acc_log.size(), 8);
    check("t1_results", out_log.size(), 8);
    if (out_log.size() == 8 && acc_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t1_data", out_log[i].data, vec[i].exp);
        check("t1_tag", out_log[i].tag, vec[i].tag);
        check("t1_result_cycle", out_log[i].cyc, acc_log[0] + 4 + i);
      end
    end

    // 2: back-pressure, only OUT_DEPTH accepted, then all ten drain in order
    co_ready = 0;
    acc_log.delete(); out_log.delete();
    for (int c = 0; c < 12; c++) begin
      ph_valid = (acc_log.size() < 10);
      ph_addr  = AW'(100 + acc_log.size());
      ph_tag   = 32'hB000_0000 + 32'(acc_log.size());
      tick();
    end
    check("t2_accepted_while_blocked", acc_log.size(), DEPTH);
    check("t2_ph_ready_low", ph_ready, 1'b0);
    co_ready = 1;
    for (int c = 0; c < 60 && acc_log.size() < 10; c++) begin
      ph_addr = AW'(100 + acc_log.size());
      ph_tag  = 32'hB000_0000 + 32'(acc_log.size());
      tick();
    end
    ph_valid = 0;
    repeat (10) tick();
    check("t2_total_accepted", acc_log.size(), 10);
    check("t2_total_results", out_log.size(), 10);
    for (int i = 0; i < out_log.size(); i++)
      check("t2_order_tag", out_log[i].tag, 32'hB000_0000 + 32'(i));

    // 3: reload while streaming
    acc_log.delete(); out_log.delete();
    for (int i = 0; i < 3; i++) begin
      ph_valid = 1; ph_addr = AW'(200 + i); ph_tag = 32'hC000_0000 + 32'(i);
      ld_start = (i == 2);
      tick();
    end
    ld_start = 0;
    ph_addr = AW'(203); ph_tag = 32'hC000_0003;
    check("t3_ph_ready_drop", ph_ready, 1'b0);
    check("t3_ld_busy", ld_busy, 1'b1);
    check("t3_ld_ready_low", ld_ready, 1'b0);
    check("t3_accept_with_start", acc_log.size(), 3);
    wait_ld_ready("t3_ld_ready_rose");
    check("t3_drained_before_load", out_log.size(), acc_log.size());
    ph_valid = 0;
    ld_valid = 1; ld_addr = AW'(5); ld_data = 64'hDEAD_BEEF_0123_4567; ld_last = 1;
    tick();
    ld_valid = 0; ld_last = 0;
    check("t3_busy_clear", ld_busy, 1'b0);
    check("t3_no_accept_in_reload", acc_log.size(), 3);
    tick();
    check("t3_bram_word", bram_mem[5], 64'hDEAD_BEEF_0123_4567);
    ph_valid = 1; ph_addr = AW'(5); ph_tag = 32'h0000_C0DE;
    tick();
    ph_valid = 0;
    repeat (6) tick();
    check("t3_lookup_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("t3_lookup_data", out_log[3].data, 64'hDEAD_BEEF_0123_4567);
      check("t3_lookup_tag", out_log[3].tag, 32'h0000_C0DE);
    end

    // 4: loader ignored in RUN; ld_start while busy ignored
    begin
      int we0;
      we0 = we_count;
      ld_valid = 1; ld_addr = AW'(7); ld_data = '1; ld_last = 1;
      #1;
      check("t4_ld_ready_in_run", ld_ready, 1'b0);
      tick();
      ld_valid = 0; ld_last = 0;
      repeat (3) tick();
      check("t4_no_bram_write", we_count, we0);
      check("t4_mem7_intact", bram_mem[7], init_word(7));
      check("t4_not_busy", ld_busy, 1'b0);
    end
    ld_start = 1; tick(); ld_start = 0;
    wait_ld_ready("t4_ld_ready");
    ld_start = 1; tick(); ld_start = 0;
    check("t4_restart_ignored_ready", ld_ready, 1'b1);
    check("t4_restart_ignored_busy", ld_busy, 1'b1);
    ld_valid = 1; ld_addr = AW'(9); ld_data = 64'h0909_0909_0909_0909; ld_last = 1;
    tick();
    ld_valid = 0; ld_last = 0;
    check("t4_load_done", ld_busy, 1'b0);

    // 5: reset in the middle of a reload
    ld_start = 1; tick(); ld_start = 0;
    wait_ld_ready("t5_ld_ready");
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1; ld_addr = AW'(20 + k); ld_data = 64'h5555_0000_0000_0000 + 64'(k);
      tick();
    end
    ld_valid = 0;
    tick();
    check("t5_nothing_pending", exp_q.size(), 0);
    rst = 1;
    #1;
    check("t5_ph_ready", ph_ready, 1'b0);
    check("t5_co_valid", co_valid, 1'b0);
    check("t5_ld_ready", ld_ready, 1'b0);
    check("t5_ld_busy", ld_busy, 1'b0);
    check("t5_bram_en", bram_en_a, 1'b0);
    check("t5_bram_we", bram_we, 1'b0);
    check("t5_bram_addr", bram_addr, '0);
    check("t5_bram_wr_data", bram_wr_data, '0);
    check("t5_co_data", co_data, '0);
    check("t5_co_tag", co_tag, '0);
    repeat (2) tick();
    rst = 0;
    tick();
    check("t5_ph_ready_resume", ph_ready, 1'b1);
    acc_log.delete(); out_log.delete();
    for (int k = 0; k < 3; k++) begin
      ph_valid = 1; ph_addr = AW'(20 + k); ph_tag = 32'hD000_0000 + 32'(k);
      tick();
    end
    ph_valid = 0;
    repeat (8) tick();
    check("t5_results", out_log.size(), 3);
    if (out_log.size() == 3)
      for (int k = 0; k < 3; k++)
        check("t5_written_word", out_log[k].data, 64'h5555_0000_0000_0000 + 64'(k));

    // Randomized lookups under random back-pressure
    for (int c = 0; c < 400; c++) begin
      ph_valid = ($urandom_range(0, 9) < 7);
      ph_addr  = AW'($urandom);
      ph_tag   = TW'($urandom);
      co_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    ph_valid = 0; co_ready = 1;
    repeat (10) tick();
    check("rand_all_returned", exp_q.size(), 0);

`ifdef ENERGY_LUT_STATS_EN
    // 6: statistics counters
    begin
      int s0;
      ld_start = 1; tick(); ld_start = 0;
      wait_ld_ready("t6_ld_ready");
      ld_valid = 1; ld_addr = AW'(30); ld_data = 64'h3030; ld_last = 1;
      tick();
      ld_valid = 0; ld_last = 0;
      check("t6_lookups_cleared", stat_lookups, 0);
      check("t6_stall_cleared", stat_stall, 0);
      acc_log.delete(); out_log.delete();
      s0 = stall_seen;
      co_ready = 0;
      for (int c = 0; c < 40 && (stall_seen - s0) < 6; c++) begin
        ph_valid = 1; ph_addr = AW'(300 + acc_log.size()); ph_tag = 32'(acc_log.size());
        tick();
      end
      co_ready = 1;
      for (int c = 0; c < 60 && acc_log.size() < 20; c++) begin
        ph_addr = AW'(300 + acc_log.size()); ph_tag = 32'(acc_log.size());
        tick();
      end
      ph_valid = 0;
      repeat (8) tick();
      check("t6_model_stalls", stall_seen - s0, 6);
      check("t6_stat_lookups", stat_lookups, 20);
      check("t6_stat_stall", stat_stall, 6);
      ld_start = 1; tick(); ld_start = 0;
      check("t6_lookups_clear_on_start", stat_lookups, 0);
      check("t6_stall_clear_on_start", stat_stall, 0);
      wait_ld_ready("t6_ld_ready2");
      ld_valid = 1; ld_addr = AW'(31); ld_data = 64'h3131; ld_last = 1;
      tick();
      ld_valid = 0; ld_last = 0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
